// File: rtl/mul_unit.sv
// mul_unit: two-stage RV32M multiply (MUL/MULH/MULHSU/MULHU), valid/ready on both sides, 2-cycle latency.
// Define MUL_OVF_EN to enable the registered MUL signed-overflow flag on out_ovf.

module mul_unit_mult (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_sign,
  output logic [63:0] o_prod
);
  logic [63:0] w_a;
  logic [63:0] w_b;

  // Sign-extend to 64 bits so the low 64 bits of the product are the signed result.
  assign w_a    = {{32{i_sign & i_a[31]}}, i_a};
  assign w_b    = {{32{i_sign & i_b[31]}}, i_b};
  assign o_prod = w_a * w_b;
endmodule

module mul_unit #(
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_rs1,
  input  logic [31:0]      in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_ovf
);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  logic             r_s1_valid;
  logic [1:0]       r_s1_op;
  logic [31:0]      r_s1_rs1;
  logic [31:0]      r_s1_rs2;
  logic [TAG_W-1:0] r_s1_tag;
  logic             r_s2_valid;
  logic [31:0]      r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic             w_s2_adv;
  logic             w_in_fire;
  logic             w_sign;
  logic [63:0]      w_prod;
  logic [31:0]      w_result;

  assign w_s2_adv  = r_s1_valid && (!r_s2_valid || out_ready);
  assign in_ready  = !flush && (!r_s1_valid || w_s2_adv);
  assign w_in_fire = in_valid && in_ready;
  assign w_sign    = (r_s1_op == OP_MULH);

  mul_unit_mult u_mult (
    .i_a    (r_s1_rs1),
    .i_b    (r_s1_rs2),
    .i_sign (w_sign),
    .o_prod (w_prod)
  );

  // MULHSU runs through the unsigned multiplier; a negative rs1 contributes -rs2 * 2^32.
  always_comb begin
    w_result = w_prod[63:32];
    case (r_s1_op)
      OP_MUL:    w_result = w_prod[31:0];
      OP_MULHSU: w_result = w_prod[63:32] - (r_s1_rs1[31] ? r_s1_rs2 : 32'd0);
      default:   w_result = w_prod[63:32];
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_op      <= 2'b00;
      r_s1_rs1     <= 32'd0;
      r_s1_rs2     <= 32'd0;
      r_s1_tag     <= '0;
      r_s2_valid   <= 1'b0;
      r_out_result <= 32'd0;
      r_out_tag    <= '0;
    end else if (flush) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r_s1_valid <= 1'b1;
        r_s1_op    <= in_op;
        r_s1_rs1   <= in_rs1;
        r_s1_rs2   <= in_rs2;
        r_s1_tag   <= in_tag;
      end else if (w_s2_adv) begin
        r_s1_valid <= 1'b0;
      end
      if (w_s2_adv) begin
        r_s2_valid   <= 1'b1;
        r_out_result <= w_result;
        r_out_tag    <= r_s1_tag;
      end else if (out_ready) begin
        r_s2_valid <= 1'b0;
      end
    end
  end

  assign out_valid  = r_s2_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

`ifdef MUL_OVF_EN
  logic [63:0] w_sprod;
  logic        w_ovf;
  logic        r_out_ovf;

  mul_unit_mult u_ovf_mult (
    .i_a    (r_s1_rs1),
    .i_b    (r_s1_rs2),
    .i_sign (1'b1),
    .o_prod (w_sprod)
  );

  assign w_ovf = (r_s1_op == OP_MUL) && (w_sprod[63:32] != {32{w_sprod[31]}});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_ovf <= 1'b0;
    end else if (!flush && w_s2_adv) begin
      r_out_ovf <= w_ovf;
    end
  end

  assign out_ovf = r_out_ovf;
`else
  assign out_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corners, back-pressure, flush, async reset and random traffic.
module tb_mul_unit;
  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_op;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic [4:0]  out_tag;
  logic        out_ovf;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] res;
    logic [4:0]  tag;
    logic        ovf;
  } exp_t;

  mul_unit #(.TAG_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag),
    .out_ovf    (out_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: full-precision product with operands interpreted per the RV32M op.
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (op)
      2'd0:    p = sa * sb;
      2'd1:    p = sa * sb;
      2'd2:    p = sa * ub;
      default: p = ua * ub;
    endcase
    return (op == 2'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic ref_ovf(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
`ifdef MUL_OVF_EN
    logic signed [63:0] p;
    p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    return (op == 2'd0) && ((p > 64'sd2147483647) || (p < -64'sd2147483648));
`else
    return (op == 2'd0) && (a === 32'hx) && (b === 32'hx);
`endif
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'd1;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  // Issue one op into an idle unit and report the cycle (relative to the handshake cycle) the result shows up.
  task automatic run_single(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] tag, output int lat, output logic [31:0] res,
                            output logic [4:0] tg, output logic ovf);
    lat = -1;
    res = 32'hx;
    tg  = 5'hx;
    ovf = 1'bx;
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_rs1    = a;
    in_rs2    = b;
    in_tag    = tag;
    out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      #1;
      if (out_valid) begin
        lat = c;
        res = out_result;
        tg  = out_tag;
        ovf = out_ovf;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== 32'd0) begin bad++; $display("FAIL reset_out_result got=%h want=0", out_result); end
    total++; if (out_tag !== 5'd0) begin bad++; $display("FAIL reset_out_tag got=%h want=0", out_tag); end
    total++; if (out_ovf !== 1'b0) begin bad++; $display("FAIL reset_out_ovf got=%b want=0", out_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_mul_basic();
    int lat; logic [31:0] res; logic [4:0] tg; logic ovf;
    run_single(2'd0, 32'd7, 32'd6, 5'd19, lat, res, tg, ovf);
    total++; if (lat != 2) begin bad++; $display("FAIL basic_latency got=%0d want=2", lat); end
    total++; if (res !== 32'h0000_002A) begin bad++; $display("FAIL basic_result got=%h want=0000002a", res); end
    total++; if (tg !== 5'd19) begin bad++; $display("FAIL basic_tag got=%0d want=19", tg); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL basic_ovf got=%b want=0", ovf); end
  endtask

  task automatic test_corners();
    logic [1:0]  t_op  [6];
    logic [31:0] t_a   [6];
    logic [31:0] t_b   [6];
    logic [31:0] t_exp [6];
    int lat; logic [31:0] res; logic [4:0] tg; logic ovf;
    t_op  = '{2'd1, 2'd3, 2'd0, 2'd2, 2'd2, 2'd0};
    t_a   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0001_0000};
    t_b   = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF, 32'h0001_0000};
    t_exp = '{32'h0000_0000, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
    for (int i = 0; i < 6; i++) begin
      run_single(t_op[i], t_a[i], t_b[i], 5'(i + 1), lat, res, tg, ovf);
      total++; if (res !== t_exp[i]) begin bad++; $display("FAIL corner%0d_result got=%h want=%h", i, res, t_exp[i]); end
      total++; if (tg !== 5'(i + 1)) begin bad++; $display("FAIL corner%0d_tag got=%0d want=%0d", i, tg, i + 1); end
      total++; if (ovf !== ref_ovf(t_op[i], t_a[i], t_b[i])) begin bad++; $display("FAIL corner%0d_ovf got=%b want=%b", i, ovf, ref_ovf(t_op[i], t_a[i], t_b[i])); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got_res [$];
    logic [4:0]  got_tag [$];
    logic        acc;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 1; i <= 2; i++) begin
      in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'(i); in_rs2 = 32'(i); in_tag = 5'(i);
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_accept%0d in_ready got=%b want=1", i, in_ready); end
      @(negedge clk);
    end
    in_rs1 = 32'd3; in_rs2 = 32'd3; in_tag = 5'd3;
    for (int c = 0; c < 3; c++) begin
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall_in_ready c%0d got=%b want=0", c, in_ready); end
      total++; if (out_valid !== 1'b1 || out_result !== 32'h1) begin bad++; $display("FAIL bp_hold c%0d got valid=%b res=%h want valid=1 res=00000001", c, out_valid, out_result); end
      @(negedge clk);
    end
    out_ready = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (out_valid) begin got_res.push_back(out_result); got_tag.push_back(out_tag); end
      acc = in_valid && in_ready;
      @(negedge clk);
      if (acc) in_valid = 1'b0;
    end
    total++; if (got_res.size() != 3) begin bad++; $display("FAIL bp_count got=%0d want=3", got_res.size()); end
    for (int i = 0; i < 3 && i < got_res.size(); i++) begin
      total++; if (got_res[i] !== 32'((i + 1) * (i + 1)) || got_tag[i] !== 5'(i + 1))
        begin bad++; $display("FAIL bp_order%0d got res=%h tag=%0d want res=%h tag=%0d", i, got_res[i], got_tag[i], (i + 1) * (i + 1), i + 1); end
    end
  endtask

  task automatic test_flush();
    logic seen;
    int lat; logic [31:0] res; logic [4:0] tg; logic ovf;
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'(5 + i); in_rs2 = 32'(5 + i); in_tag = 5'(10 + i);
      @(negedge clk);
    end
    flush = 1'b1; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 5'd12;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready got=%b want=0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_out_valid got=%b want=0", out_valid); end
    out_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL flush_leak got=%b want=0", seen); end
    run_single(2'd3, 32'h0001_0000, 32'h0003_0000, 5'd21, lat, res, tg, ovf);
    total++; if (lat != 2) begin bad++; $display("FAIL flush_after_latency got=%0d want=2", lat); end
    total++; if (res !== 32'h0000_0003 || tg !== 5'd21) begin bad++; $display("FAIL flush_after_result got res=%h tag=%0d want res=00000003 tag=21", res, tg); end
  endtask

  task automatic test_random();
    exp_t q [$];
    exp_t e;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (c < 600) begin
        in_valid  = ($urandom_range(0, 3) != 0);
        in_op     = 2'($urandom_range(0, 3));
        in_rs1    = pick();
        in_rs2    = pick();
        in_tag    = 5'($urandom_range(0, 31));
        out_ready = ($urandom_range(0, 3) != 0);
      end else begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++; bad++; $display("FAIL rnd_spurious cycle=%0d got res=%h want no output", c, out_result);
        end else begin
          e = q.pop_front();
          total++; if (out_result !== e.res) begin bad++; $display("FAIL rnd_result cycle=%0d got=%h want=%h", c, out_result, e.res); end
          total++; if (out_tag !== e.tag) begin bad++; $display("FAIL rnd_tag cycle=%0d got=%0d want=%0d", c, out_tag, e.tag); end
          total++; if (out_ovf !== e.ovf) begin bad++; $display("FAIL rnd_ovf cycle=%0d got=%b want=%b", c, out_ovf, e.ovf); end
        end
      end
      if (in_valid && in_ready) begin
        e.res = ref_result(in_op, in_rs1, in_rs2);
        e.tag = in_tag;
        e.ovf = ref_ovf(in_op, in_rs1, in_rs2);
        q.push_back(e);
      end
    end
    total++; if (q.size() != 0) begin bad++; $display("FAIL rnd_lost got=%0d pending want=0", q.size()); end
  endtask

  task automatic test_async_reset();
    int lat; logic [31:0] res; logic [4:0] tg; logic ovf;
    @(negedge clk);
    out_ready = 1'b0;
    in_valid = 1'b1; in_op = 2'd0; in_rs1 = 32'd3; in_rs2 = 32'd5; in_tag = 5'd7;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    #1;
    total++; if (out_valid !== 1'b1 || out_result !== 32'd15) begin bad++; $display("FAIL arst_pre got valid=%b res=%h want valid=1 res=0000000f", out_valid, out_result); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL arst_out_valid got=%b want=0", out_valid); end
    total++; if (out_result !== 32'd0 || out_tag !== 5'd0) begin bad++; $display("FAIL arst_data got res=%h tag=%0d want 0/0", out_result, out_tag); end
    @(negedge clk);
    rst_n = 1'b1;
    run_single(2'd0, 32'h0001_0000, 32'h0001_0000, 5'd3, lat, res, tg, ovf);
    total++; if (lat != 2) begin bad++; $display("FAIL arst_after_latency got=%0d want=2", lat); end
    total++; if (res !== 32'd0 || tg !== 5'd3) begin bad++; $display("FAIL arst_after_result got res=%h tag=%0d want res=00000000 tag=3", res, tg); end
`ifdef MUL_OVF_EN
    total++; if (ovf !== 1'b1) begin bad++; $display("FAIL arst_after_ovf got=%b want=1", ovf); end
`else
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL arst_after_ovf got=%b want=0", ovf); end
`endif
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_op     = 2'd0;
    in_rs1    = 32'd0;
    in_rs2    = 32'd0;
    in_tag    = 5'd0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    test_reset();
    test_mul_basic();
    test_corners();
    test_back_to_back();
    test_flush();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/mul_unit.md
Name: mul_unit

Overview:
- Pipelined RV32M multiply stage that sits directly upstream of the combinational 32x32 Multiplier and registers its product.
- Decodes MUL/MULH/MULHSU/MULHU from the 2-bit op, drives the Multiplier's a/b/sign inputs, corrects the MULHSU upper half, and selects the 32-bit result.
- Valid/ready handshake on both sides; fixed 2-cycle latency; feeds the writeback mux.

Parameters:
TAG_W, 5, width of the opaque tag (rd index) carried alongside each operation

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of all in-flight operations
in_valid  input  1  operation offered
in_ready  output  1  unit accepts the operation this cycle
in_op  input  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0])
in_rs1  input  32  operand a
in_rs2  input  32  operand b
in_tag  input  TAG_W  tag passed through unchanged
out_valid  output  1  result available
out_ready  input  1  consumer takes the result this cycle
out_result  output  32  selected result word
out_tag  output  TAG_W  tag of the result
out_ovf  output  1  MUL overflow flag (see Optional Feature)

Behaviour:
- Reset (rst_n low, asynchronous): s1_valid=0, s2_valid=0, out_valid=0, out_result=0, out_tag=0, out_ovf=0. Operand and op registers are cleared to 0.
- Stage S1 registers op, rs1, rs2 and tag. S1 drives the Multiplier: a=rs1, b=rs2, sign=1 for MULH and 0 otherwise.
- Stage S2 registers the selected result from the S1 product:
  - MUL: prod[31:0].
  - MULH: prod[63:32] (signed product).
  - MULHU: prod[63:32] (unsigned product).
  - MULHSU: unsigned prod[63:32] minus (rs1[31] ? rs2 : 0), mod 2^32.
- Advance rules:
  - s2_adv = s1_valid && (!s2_valid || out_ready).
  - in_ready = !s1_valid || s2_adv. in_ready is combinational and depends on out_ready.
  - Accept into S1 when in_valid && in_ready.
- Latency: an operation accepted at edge N presents out_valid at edge N+2 if not stalled. Throughput is 1 op/cycle, and results are returned in issue order.
- Stall: while out_valid && !out_ready, the S2 contents hold stable and S1 holds. At most 2 operations are in flight.
- Simultaneous events: a same-cycle S2 drain and S1 refill is legal and loses no data.
- flush: the next edge clears s1_valid and s2_valid and sets out_valid to 0. An in_valid presented in the flush cycle is not accepted, and in_ready is 0 during flush. flush has priority over every advance.
- Reset mid-operation drops all in-flight operations. No output is produced for them.

Optional Feature:
- Macro: MUL_OVF_EN.
- Defined: for op MUL, out_ovf=1 when the signed 64-bit product differs from the sign-extension of prod[31:0]. The product is obtained from a second Multiplier instance with sign=1, or equivalent logic. For all other ops out_ovf=0. out_ovf is registered in S2 alongside out_result.
- Undefined: out_ovf is tied to 0 and the extra logic is absent. The port list is unchanged.

Test Plan:
- MUL rs1=7, rs2=6, out_ready=1 -> out_valid exactly 2 cycles after acceptance, out_result=0x0000002A, tag echoed.
- rs1=rs2=0xFFFFFFFF -> MULH returns 0x00000000; MULHU returns 0xFFFFFFFE; MUL returns 0x00000001.
- MULHSU rs1=0xFFFFFFFF, rs2=0x00000002 -> out_result=0xFFFFFFFF. MULHSU rs1=0x80000000, rs2=0xFFFFFFFF -> out_result=0x80000000.
- Back-pressure: issue 3 back-to-back MULs (1x1, 2x2, 3x3) with out_ready=0 -> in_ready drops after 2 accepts and out_result holds 0x1. Then out_ready=1 -> results 0x1, 0x4, 0x9 appear in order with no loss or duplication.
- Pulse flush with 2 operations in flight -> out_valid=0 on the next cycle and the flushed results never appear. An op issued afterwards completes normally.
- Assert rst_n low asynchronously with out_valid=1 -> out_valid, out_result and out_tag go to 0 immediately. After release, the first new op completes with 2-cycle latency. With MUL_OVF_EN defined, MUL 0x00010000 x 0x00010000 -> out_ovf=1 and out_result=0.
